time_set_ctrl: RTL

Time-keeping and time-setting controller for the clock display path. It owns the hours/minutes/seconds registers and advances them from a 1 Hz tick in run mode. It also sequences a set-mode state machine driven by a debounced push-button pulse and by the left/right rotation event pulses from the rotary-encoder decoder. It sits between the encoder decoder / tick generator and the display formatter.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/field_counter.sv | 43 ++++
 rtl/time_set_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings, limits and field widths for the clock display path.
package clock_pkg;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned TO_W  = 8;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR24_MAX = 23;
  localparam int unsigned HR12_MIN = 1;
  localparam int unsigned HR12_MAX = 12;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_e;

endpackage

// File: rtl/field_counter.sv
// Wrapping MIN..MAX up/down counter; carry_c pulses on the up-wrap.
module field_counter #(
  parameter int unsigned W       = 6,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned RST_VAL = MIN_VAL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         carry_c
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    value_d = value_q;
    carry_c = 1'b0;
    if (inc && !dec) begin
      if (value_q == W'(MAX_VAL)) begin
        value_d = W'(MIN_VAL);
        carry_c = 1'b1;
      end else begin
        value_d = value_q + W'(1);
      end
    end else if (dec && !inc) begin
      if (value_q == W'(MIN_VAL)) value_d = W'(MAX_VAL);
      else                        value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= W'(RST_VAL);
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-keeping and set-mode controller: hh:mm:ss registers, RUN/SET FSM, inactivity timeout.
// Optional 12-hour display with pm flag via `define TWELVE_HOUR_EN.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             btn_event,
  input  logic             event_rot_l,
  input  logic             event_rot_r,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             pm,
  output logic [1:0]       mode,
  output logic             set_active
);

`ifdef TWELVE_HOUR_EN
  localparam int unsigned HR_RST = HR12_MAX;
`else
  localparam int unsigned HR_RST = 0;
`endif

  mode_e             state_q, state_d;
  logic              set_active_q, set_active_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]   to_inc;
  logic [HR_W-1:0]   hours_q, hours_d;
  logic              timeout_c;
  logic              is_run_c;
  logic              rot_inc_c, rot_dec_c;
  logic              sec_inc_c, sec_dec_c, sec_carry_c;
  logic              min_inc_c, min_dec_c, min_carry_c;
  logic              hr_inc_c, hr_dec_c;

  assign is_run_c  = (state_q == MODE_RUN);
  // The button wins over rotation; opposing rotations cancel.
  assign rot_inc_c = event_rot_r && !event_rot_l && !btn_event;
  assign rot_dec_c = event_rot_l && !event_rot_r && !btn_event;

  assign sec_inc_c = (is_run_c && tick_1hz) || (state_q == MODE_SET_SEC && rot_inc_c);
  assign sec_dec_c = (state_q == MODE_SET_SEC) && rot_dec_c;
  assign min_inc_c = (is_run_c && tick_1hz && sec_carry_c) || (state_q == MODE_SET_MIN && rot_inc_c);
  assign min_dec_c = (state_q == MODE_SET_MIN) && rot_dec_c;
  assign hr_inc_c  = (is_run_c && tick_1hz && sec_carry_c && min_carry_c) ||
                     (state_q == MODE_SET_HR && rot_inc_c);
  assign hr_dec_c  = (state_q == MODE_SET_HR) && rot_dec_c;

  field_counter #(.W(SEC_W), .MIN_VAL(0), .MAX_VAL(SEC_MAX)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .inc     (sec_inc_c),
    .dec     (sec_dec_c),
    .value   (seconds),
    .carry_c (sec_carry_c)
  );

  field_counter #(.W(MIN_W), .MIN_VAL(0), .MAX_VAL(MIN_MAX)) u_min (
    .clk     (clk),
    .rst     (rst),
    .inc     (min_inc_c),
    .dec     (min_dec_c),
    .value   (minutes),
    .carry_c (min_carry_c)
  );

  // Inactivity timer: exit fires on the tick that makes the count reach TIMEOUT_S.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_inc    = to_cnt_q + TO_W'(1);
    timeout_c = 1'b0;
    if (is_run_c || btn_event || event_rot_l || event_rot_r) begin
      to_cnt_d = '0;
    end else if (tick_1hz) begin
      if (TIMEOUT_S != 0 && to_inc == TO_W'(TIMEOUT_S)) begin
        timeout_c = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d  = to_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:     if (btn_event) state_d = MODE_SET_HR;
      MODE_SET_HR:  if (btn_event) state_d = MODE_SET_MIN; else if (timeout_c) state_d = MODE_RUN;
      MODE_SET_MIN: if (btn_event) state_d = MODE_SET_SEC; else if (timeout_c) state_d = MODE_RUN;
      MODE_SET_SEC: if (btn_event || timeout_c) state_d = MODE_RUN;
      default:      state_d = MODE_RUN;
    endcase
    set_active_d = (state_d != MODE_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MODE_RUN;
      set_active_q <= 1'b0;
      to_cnt_q     <= '0;
      hours_q      <= HR_W'(HR_RST);
    end else begin
      state_q      <= state_d;
      set_active_q <= set_active_d;
      to_cnt_q     <= to_cnt_d;
      hours_q      <= hours_d;
    end
  end

`ifdef TWELVE_HOUR_EN
  logic pm_q, pm_d;

  // 12-hour sequence: pm flips across the 11/12 boundary in either direction.
  always_comb begin
    hours_d = hours_q;
    pm_d    = pm_q;
    if (hr_inc_c && !hr_dec_c) begin
      if (hours_q == HR_W'(HR12_MAX)) begin
        hours_d = HR_W'(HR12_MIN);
      end else begin
        hours_d = hours_q + HR_W'(1);
        if (hours_q == HR_W'(HR12_MAX - 1)) pm_d = !pm_q;
      end
    end else if (hr_dec_c && !hr_inc_c) begin
      if (hours_q == HR_W'(HR12_MIN)) begin
        hours_d = HR_W'(HR12_MAX);
      end else begin
        hours_d = hours_q - HR_W'(1);
        if (hours_q == HR_W'(HR12_MAX)) pm_d = !pm_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pm_q <= 1'b0;
    else     pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  always_comb begin
    hours_d = hours_q;
    if (hr_inc_c && !hr_dec_c) begin
      if (hours_q == HR_W'(HR24_MAX)) hours_d = '0;
      else                            hours_d = hours_q + HR_W'(1);
    end else if (hr_dec_c && !hr_inc_c) begin
      if (hours_q == '0) hours_d = HR_W'(HR24_MAX);
      else               hours_d = hours_q - HR_W'(1);
    end
  end

  assign pm = 1'b0;
`endif

  assign hours      = hours_q;
  assign mode       = 2'(state_q);
  assign set_active = set_active_q;

endmodule
